// File: rtl/sram_responder.sv
// sram_responder: clocked emulator of the DE2 256Kx16 asynchronous SRAM that answers the
// controller from an on-chip array and reports write/read activity and out-of-range accesses.
module sram_responder #(
  parameter int DEPTH_LOG2   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        CS,
  input  logic        SRAM_Write_Enable,
  input  logic        SRAM_Output_Enable,
  input  logic        HbMask,
  input  logic        LbMask,
  input  logic [17:0] SRAM_Address,
  inout  wire  [15:0] SRAM_Data,
  output logic [15:0] Write_Count,
  output logic [15:0] Read_Count,
  output logic        Out_Of_Range
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_HOLD,
    READ_WAIT,
    READ_DRIVE
  } state_t;

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(READ_LATENCY - 1);

  state_t      state, state_next;
  logic [17:0] addr_q, addr_next;
  logic [3:0]  wait_q, wait_next;
  logic [15:0] read_data_q;
  logic [15:0] mem [DEPTH];

  logic wr_cond, rd_cond;
  logic addr_oor, addr_q_oor, addr_changed;
  logic from_idle, commit, latch_read, enter_drive, drive_en;

  assign wr_cond      = !CS && !SRAM_Write_Enable;
  assign rd_cond      = !CS && SRAM_Write_Enable && !SRAM_Output_Enable;
  assign addr_oor     = (SRAM_Address >> DEPTH_LOG2) != 18'd0;
  assign addr_q_oor   = (addr_q >> DEPTH_LOG2) != 18'd0;
  assign addr_changed = SRAM_Address != addr_q;

  // A write always restarts as from IDLE; a read right after a write hold is accepted
  // on the edge that sees the write drop, so write-then-read keeps full latency.
  assign from_idle = (state == IDLE)
                  || (state == WRITE_HOLD && !wr_cond)
                  || ((state == READ_WAIT || state == READ_DRIVE) && wr_cond);

  always_comb begin
    state_next  = state;
    addr_next   = addr_q;
    wait_next   = wait_q;
    commit      = 1'b0;
    latch_read  = 1'b0;
    enter_drive = 1'b0;
    if (from_idle) begin
      if (wr_cond) begin
        commit     = 1'b1;
        addr_next  = SRAM_Address;
        state_next = WRITE_HOLD;
      end else if (rd_cond) begin
        latch_read = 1'b1;
        addr_next  = SRAM_Address;
        wait_next  = WAIT_LOAD;
        state_next = READ_WAIT;
      end else begin
        state_next = IDLE;
      end
    end else begin
      unique case (state)
        WRITE_HOLD: begin
          if (addr_changed) begin
            commit    = 1'b1;
            addr_next = SRAM_Address;
          end
        end
        READ_WAIT: begin
          if (!rd_cond) begin
            state_next = IDLE;
          end else if (addr_changed) begin
            latch_read = 1'b1;
            addr_next  = SRAM_Address;
            wait_next  = WAIT_LOAD;
          end else if (wait_q == 4'd0) begin
            enter_drive = 1'b1;
            state_next  = READ_DRIVE;
          end else begin
            wait_next = wait_q - 4'd1;
          end
        end
        READ_DRIVE: begin
          if (!rd_cond) begin
            state_next = IDLE;
          end else if (addr_changed) begin
            latch_read = 1'b1;
            addr_next  = SRAM_Address;
            wait_next  = WAIT_LOAD;
            state_next = READ_WAIT;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      wait_q       <= '0;
      read_data_q  <= '0;
      Write_Count  <= '0;
      Read_Count   <= '0;
      Out_Of_Range <= 1'b0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
      wait_q <= wait_next;
      if (commit && !addr_oor && Write_Count != 16'hFFFF)
        Write_Count <= Write_Count + 16'd1;
      if (enter_drive && Read_Count != 16'hFFFF)
        Read_Count <= Read_Count + 16'd1;
      if ((commit || latch_read) && addr_oor)
        Out_Of_Range <= 1'b1;
      if (enter_drive)
        read_data_q <= addr_q_oor ? 16'h0000 : mem[addr_q[DEPTH_LOG2-1:0]];
    end
  end

  // Array has no reset so it can map onto block/distributed RAM with byte enables.
  always_ff @(posedge Clock) begin
    if (Reset_n && commit && !addr_oor) begin
      if (!HbMask) mem[SRAM_Address[DEPTH_LOG2-1:0]][15:8] <= SRAM_Data[15:8];
      if (!LbMask) mem[SRAM_Address[DEPTH_LOG2-1:0]][7:0]  <= SRAM_Data[7:0];
    end
  end

  // Dropping write enable releases the bus combinationally so the controller can drive at once.
  assign drive_en = Reset_n && (state == READ_DRIVE) && SRAM_Write_Enable;

  assign SRAM_Data[15:8] = (drive_en && !HbMask) ? read_data_q[15:8] : 8'hzz;
  assign SRAM_Data[7:0]  = (drive_en && !LbMask) ? read_data_q[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized self-checking bench for sram_responder against a
// transaction-level memory model; a released bus reads back as all ones via tri1.
module tb_sram_responder;

  localparam int DL = 8;
  localparam int RL = 2;

  logic        clock;
  logic        reset_n;
  logic        cs;
  logic        we;
  logic        oe;
  logic        hb_mask;
  logic        lb_mask;
  logic [17:0] address;
  logic [15:0] tb_data;
  logic        tb_drive;
  tri1  [15:0] data_bus;
  logic [15:0] write_count;
  logic [15:0] read_count;
  logic        out_of_range;

  int checks;
  int fails;

  logic [15:0] model_mem [256];
  int          model_wc;
  int          model_rc;
  logic        model_oor;

  assign data_bus = tb_drive ? tb_data : 16'hzzzz;

  sram_responder #(
    .DEPTH_LOG2  (DL),
    .READ_LATENCY(RL)
  ) dut (
    .Clock             (clock),
    .Reset_n           (reset_n),
    .CS                (cs),
    .SRAM_Write_Enable (we),
    .SRAM_Output_Enable(oe),
    .HbMask            (hb_mask),
    .LbMask            (lb_mask),
    .SRAM_Address      (address),
    .SRAM_Data         (data_bus),
    .Write_Count       (write_count),
    .Read_Count        (read_count),
    .Out_Of_Range      (out_of_range)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    cs       = 1'b1;
    we       = 1'b1;
    oe       = 1'b1;
    hb_mask  = 1'b0;
    lb_mask  = 1'b0;
    tb_drive = 1'b0;
  endtask

  task automatic model_write(input logic [17:0] a, input logic [15:0] d, input logic hbm,
                             input logic lbm);
    if ((a >> DL) != 18'd0) begin
      model_oor = 1'b1;
    end else begin
      if (!hbm) model_mem[a[7:0]][15:8] = d[15:8];
      if (!lbm) model_mem[a[7:0]][7:0]  = d[7:0];
      model_wc++;
    end
  endtask

  function automatic logic [15:0] model_read(input logic [17:0] a, input logic hbm,
                                             input logic lbm);
    logic [15:0] v;
    v = ((a >> DL) != 18'd0) ? 16'h0000 : model_mem[a[7:0]];
    if (hbm) v[15:8] = 8'hFF;
    if (lbm) v[7:0]  = 8'hFF;
    return v;
  endfunction

  // Single-cycle write; optionally leaves the write asserted-then-dropped bus idle.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic hbm,
                          input logic lbm, input bit then_idle);
    cs = 1'b0; we = 1'b0; oe = 1'b1;
    hb_mask = hbm; lb_mask = lbm;
    address = a; tb_data = d; tb_drive = 1'b1;
    step();
    model_write(a, d, hbm, lbm);
    checks++;
    if (write_count !== 16'(model_wc)) begin
      fails++;
      $display("[TB] FAIL write_count addr=%h got=%0d want=%0d", a, write_count, model_wc);
    end
    checks++;
    if (out_of_range !== model_oor) begin
      fails++;
      $display("[TB] FAIL oor_after_write addr=%h got=%b want=%b", a, out_of_range, model_oor);
    end
    if (then_idle) begin
      idle_bus();
      step();
    end
  endtask

  // Read with fixed masks: bus must stay released until latency elapses, then show data.
  task automatic do_read(input logic [17:0] a, input logic hbm, input logic lbm,
                         input bit then_idle);
    logic [15:0] exp;
    cs = 1'b0; we = 1'b1; oe = 1'b0;
    hb_mask = hbm; lb_mask = lbm;
    address = a; tb_drive = 1'b0;
    repeat (RL) step();
    checks++;
    if (data_bus !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL read_early addr=%h got=%h want=%h", a, data_bus, 16'hFFFF);
    end
    step();
    if ((a >> DL) != 18'd0) model_oor = 1'b1;
    model_rc++;
    exp = model_read(a, hbm, lbm);
    checks++;
    if (data_bus !== exp) begin
      fails++;
      $display("[TB] FAIL read_data addr=%h hb=%b lb=%b got=%h want=%h", a, hbm, lbm,
               data_bus, exp);
    end
    checks++;
    if (read_count !== 16'(model_rc)) begin
      fails++;
      $display("[TB] FAIL read_count addr=%h got=%0d want=%0d", a, read_count, model_rc);
    end
    checks++;
    if (out_of_range !== model_oor) begin
      fails++;
      $display("[TB] FAIL oor_after_read addr=%h got=%b want=%b", a, out_of_range, model_oor);
    end
    if (then_idle) begin
      idle_bus();
      step();
    end
  endtask

  task automatic test_reset();
    idle_bus();
    address = '0; tb_data = '0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    model_wc = 0; model_rc = 0; model_oor = 1'b0;
    checks++;
    if (write_count !== 16'd0) begin
      fails++; $display("[TB] FAIL reset_wc got=%0d want=0", write_count);
    end
    checks++;
    if (read_count !== 16'd0) begin
      fails++; $display("[TB] FAIL reset_rc got=%0d want=0", read_count);
    end
    checks++;
    if (out_of_range !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_oor got=%b want=0", out_of_range);
    end
    checks++;
    if (data_bus !== 16'hFFFF) begin
      fails++; $display("[TB] FAIL reset_bus got=%h want=FFFF", data_bus);
    end
  endtask

  task automatic test_basic();
    do_write(18'd5, 16'hA55A, 1'b0, 1'b0, 1);
    do_read(18'd5, 1'b0, 1'b0, 1);
  endtask

  task automatic test_byte_lanes();
    do_write(18'd3, 16'h1234, 1'b0, 1'b0, 1);
    do_write(18'd3, 16'hFFFF, 1'b1, 1'b0, 1);
    do_read(18'd3, 1'b0, 1'b0, 1);
    do_read(18'd3, 1'b0, 1'b1, 1);
    do_write(18'd4, 16'h1234, 1'b0, 1'b0, 1);
    do_read(18'd4, 1'b0, 1'b1, 1);
    do_read(18'd4, 1'b1, 1'b0, 1);
  endtask

  task automatic test_held_write();
    int wc_before;
    wc_before = model_wc;
    cs = 1'b0; we = 1'b0; oe = 1'b1; hb_mask = 1'b0; lb_mask = 1'b0; tb_drive = 1'b1;
    for (int i = 0; i < 10; i++) begin
      address = 18'((i / 2 > 3) ? 3 : i / 2);
      tb_data = 16'(address);
      step();
    end
    idle_bus();
    step();
    for (int a = 0; a < 4; a++) model_write(18'(a), 16'(a), 1'b0, 1'b0);
    checks++;
    if (write_count !== 16'(wc_before + 4)) begin
      fails++;
      $display("[TB] FAIL held_write_count got=%0d want=%0d", write_count, wc_before + 4);
    end
    for (int a = 0; a < 4; a++) do_read(18'(a), 1'b0, 1'b0, 1);
    // Sweep every word so the model knows the whole array for random reads later.
    cs = 1'b0; we = 1'b0; tb_drive = 1'b1;
    for (int a = 0; a < 256; a++) begin
      address = 18'(a);
      tb_data = 16'(a);
      step();
      model_write(18'(a), 16'(a), 1'b0, 1'b0);
    end
    idle_bus();
    step();
    checks++;
    if (write_count !== 16'(model_wc)) begin
      fails++;
      $display("[TB] FAIL sweep_write_count got=%0d want=%0d", write_count, model_wc);
    end
    for (int a = 250; a < 256; a++) do_read(18'(a), 1'b0, 1'b0, 1);
  endtask

  task automatic test_out_of_range();
    do_write(18'h00000, 16'h5A5A, 1'b0, 1'b0, 1);
    do_write(18'h00100, 16'hDEAD, 1'b0, 1'b0, 1);
    do_read(18'h00100, 1'b0, 1'b0, 1);
    do_read(18'h00000, 1'b0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    do_write(18'd10, 16'hC0DE, 1'b0, 1'b0, 0);
    do_read(18'd10, 1'b0, 1'b0, 0);
    address = 18'd11;
    step();
    checks++;
    if (data_bus !== 16'hFFFF) begin
      fails++; $display("[TB] FAIL addr_change_release got=%h want=FFFF", data_bus);
    end
    repeat (RL) step();
    model_rc++;
    checks++;
    if (data_bus !== model_read(18'd11, 1'b0, 1'b0)) begin
      fails++;
      $display("[TB] FAIL addr_change_data got=%h want=%h", data_bus,
               model_read(18'd11, 1'b0, 1'b0));
    end
    checks++;
    if (read_count !== 16'(model_rc)) begin
      fails++; $display("[TB] FAIL addr_change_rc got=%0d want=%0d", read_count, model_rc);
    end
    idle_bus();
    step();
  endtask

  task automatic test_turnaround();
    do_write(18'd7, 16'h0BAD, 1'b0, 1'b0, 1);
    do_read(18'd7, 1'b0, 1'b0, 0);
    we = 1'b0; tb_data = 16'h7E57; tb_drive = 1'b1;
    #1;
    checks++;
    if (data_bus !== 16'h7E57) begin
      fails++; $display("[TB] FAIL turnaround_contention got=%h want=7E57", data_bus);
    end
    step();
    model_write(18'd7, 16'h7E57, 1'b0, 1'b0);
    checks++;
    if (write_count !== 16'(model_wc)) begin
      fails++; $display("[TB] FAIL turnaround_wc got=%0d want=%0d", write_count, model_wc);
    end
    idle_bus();
    step();
    do_read(18'd7, 1'b0, 1'b0, 1);
  endtask

  task automatic test_reset_in_drive();
    do_read(18'd7, 1'b0, 1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_bus !== 16'hFFFF) begin
      fails++; $display("[TB] FAIL async_reset_bus got=%h want=FFFF", data_bus);
    end
    checks++;
    if (write_count !== 16'd0 || read_count !== 16'd0 || out_of_range !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset_status wc=%0d rc=%0d oor=%b want 0/0/0", write_count,
               read_count, out_of_range);
    end
    idle_bus();
    step();
    reset_n = 1'b1;
    step();
    model_wc = 0; model_rc = 0; model_oor = 1'b0;
    do_read(18'd7, 1'b0, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [17:0] a;
    logic [15:0] d;
    for (int n = 0; n < 80; n++) begin
      a = 18'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a[17:DL] = 10'($urandom_range(1, 1023));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_write(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      else
        do_read(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_held_write();
    test_out_of_range();
    test_back_to_back();
    test_turnaround();
    test_reset_in_drive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
